pixmem_arbiter: RTL and testbench
=================================

# pixmem_arbiter

Arbiter for the single-port pixel memory shared by the `MemPix` stage of the hybrid ARM/MIPS pipeline and the display scanout reader. It grants at most one access per cycle and drives the memory port. It stalls the pipeline while the CPU request is waiting, and steers 1-cycle-latency read data back to the owner of the read. Priority order is: starvation guard, then urgent display, then round-robin. `halt` freezes CPU access without blocking scanout.

## Interface
- `ADDR_W`, 17, pixel memory word-address width
- `DATA_W`, 32, data width
- `MAX_WAIT`, 8, number of consecutive denied CPU cycles before the CPU is force-granted (≥1)

- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `halt`  in  1  pipeline halted; CPU requests are ineligible while high
- `cpu_req`  in  1  CPU access request, held until granted
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_gnt`  out  1  CPU access issued this cycle (combinational)
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`
- `cpu_rvalid`  out  1  CPU read data valid (registered)
- `cpu_rdata`  out  DATA_W  `mem_rdata` when `cpu_rvalid` is high, else 0
- `dsp_req`  in  1  display read request
- `dsp_urgent`  in  1  display FIFO near empty
- `dsp_addr`  in  ADDR_W  display address
- `dsp_gnt`  out  1  display access issued this cycle (combinational)
- `dsp_rvalid`  out  1  display read data valid (registered)
- `dsp_rdata`  out  DATA_W  `mem_rdata` when `dsp_rvalid` is high, else 0
- `mem_en`, `mem_we`  out  1  memory enable / write enable
- `mem_addr`  out  ADDR_W, `mem_wdata`  out  DATA_W  memory port
- `mem_rdata`  in  DATA_W  read data, valid on the cycle after `mem_en & ~mem_we`

## Operation
- `cpu_elig = cpu_req & ~halt`.
- Registered state:
  - `last_owner`: 0 = CPU, 1 = display; reset value 1.
  - `wait_cnt`: width `$clog2(MAX_WAIT+1)`; reset value 0.
  - `rv_cpu`, `rv_dsp`: reset value 0.
- Grant decision, combinational, first matching rule wins:
  1. `cpu_elig` and `wait_cnt == MAX_WAIT`: grant CPU.
  2. `dsp_req & dsp_urgent`: grant display.
  3. `cpu_elig & dsp_req`: grant the requester that is not `last_owner`.
  4. `cpu_elig` only: grant CPU. `dsp_req` only: grant display.
  5. No requests: no grant.
- `cpu_gnt` and `dsp_gnt` are never both high.
- `mem_en = cpu_gnt | dsp_gnt`.
- `mem_we = cpu_gnt & cpu_we`. The display never writes.
- `mem_addr` and `mem_wdata` are muxed from the granted requester. Both are 0 when there is no grant.
- `last_owner` updates only on a grant.
- `wait_cnt`:
  - clears to 0 on `cpu_gnt` or when `~cpu_elig`;
  - otherwise increments, saturating at `MAX_WAIT`.
- `rv_cpu <= cpu_gnt & ~cpu_we`; `rv_dsp <= dsp_gnt`. These drive `cpu_rvalid` and `dsp_rvalid`.
- While `halt` is high, `cpu_stall` stays high if `cpu_req` is high. The display is served normally.
- Reset asserted, at any time:
  - all registers go to their reset values immediately;
  - `cpu_gnt`, `dsp_gnt` and `mem_en` are forced to 0;
  - a read in flight is dropped and its `rvalid` is never issued.

## Timing
- Grant latency is 0 cycles: `gnt` follows `req` combinationally in the same cycle.
- Read data latency is 1 cycle: `rvalid` and `rdata` appear on the cycle after the grant.
- Writes complete on the grant edge and produce no `rvalid`.
- Back-to-back grants are allowed every cycle. `rvalid` for cycle N overlaps the grant for cycle N+1.
- Worst-case CPU wait is `MAX_WAIT` cycles after the request becomes eligible, even when `dsp_urgent` is held continuously.
- `halt` takes effect in the same cycle. No new CPU grant is issued, but an already registered `cpu_rvalid` still fires.
- Reset deassertion is synchronized externally. The first grant is possible on the first edge after release; on a tie that grant goes to the CPU, because `last_owner` resets to 1.

## Test plan
- **Reset and idle.**
  - Stimulus: `reset` low, all requests high.
  - Required response: both grants 0, `mem_en` 0, both `rvalid` 0.
  - Then release reset with no requests: outputs stay 0.
- **Tie, round-robin.**
  - Stimulus: `cpu_req` and `dsp_req` both held, `dsp_urgent` = 0, for 6 cycles.
  - Required response: grants go CPU, display, CPU, display, CPU, display.
  - `cpu_stall` is high on the display-granted cycles.
- **Read return path.**
  - Stimulus: CPU reads address 0x00010, memory model returns 0xDEADBEEF.
  - Required response: `cpu_rvalid` high exactly one cycle later with `cpu_rdata` = 0xDEADBEEF; `dsp_rvalid` stays 0.
  - Also check that a CPU write produces no `rvalid`.
- **Urgent display and starvation.**
  - Stimulus: `dsp_req` and `dsp_urgent` held, `cpu_req` held, `MAX_WAIT` = 8.
  - Required response: display granted for 8 cycles, CPU granted on the 9th, then display again.
- **Halt.**
  - Stimulus: `halt` = 1, `cpu_req` = 1, `dsp_req` toggling.
  - Required response: `cpu_gnt` stays 0, `cpu_stall` stays 1, `wait_cnt` stays 0, display is granted whenever it requests.
  - After `halt` drops, the CPU is granted in the same cycle.
- **Reset mid-read.**
  - Stimulus: CPU read granted, then `reset` asserted low between the clock edges before `rvalid`.
  - Required response: `cpu_rvalid` never asserts, and `last_owner` returns to 1.

Source files
------------

// File: rtl/pixmem_arbiter_if.sv
// Shared pixel-memory bus: CPU request side, display request side and memory port.
interface pixmem_arbiter_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 32
);
  // CPU (MemPix stage) side
  logic              halt;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  // Display scanout side
  logic              dsp_req;
  logic              dsp_urgent;
  logic [ADDR_W-1:0] dsp_addr;
  logic              dsp_gnt;
  logic              dsp_rvalid;
  logic [DATA_W-1:0] dsp_rdata;
  // Memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  halt, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  dsp_req, dsp_urgent, dsp_addr,
    output dsp_gnt, dsp_rvalid, dsp_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output halt, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output dsp_req, dsp_urgent, dsp_addr,
    input  dsp_gnt, dsp_rvalid, dsp_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/pixmem_arbiter.sv
// Single-port pixel memory arbiter between the CPU MemPix stage and display scanout.
// Priority: starvation guard, urgent display, round-robin. Read data returns one cycle
// after the grant and is steered to whichever requester issued the read.
module pixmem_arbiter #(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic            clk,
  input  logic            reset,
  pixmem_arbiter_if.slave bus
);

  localparam int unsigned       WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic {OWN_CPU = 1'b0, OWN_DSP = 1'b1} owner_e;

  owner_e            last_owner;
  owner_e            last_owner_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_nxt;
  logic              rv_cpu;
  logic              rv_dsp;
  logic              cpu_elig;
  logic              cpu_gnt_c;
  logic              dsp_gnt_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;

  assign cpu_elig = bus.cpu_req & ~bus.halt;

  // Owner history, CPU starvation counter and read-return tags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_owner <= OWN_DSP;
      wait_cnt   <= '0;
      rv_cpu     <= 1'b0;
      rv_dsp     <= 1'b0;
    end else begin
      last_owner <= last_owner_nxt;
      wait_cnt   <= wait_cnt_nxt;
      rv_cpu     <= cpu_gnt_c & ~bus.cpu_we;
      rv_dsp     <= dsp_gnt_c;
    end
  end

  // Grant decision and next-state; grants are held off while reset is asserted
  always_comb begin
    cpu_gnt_c      = 1'b0;
    dsp_gnt_c      = 1'b0;
    last_owner_nxt = last_owner;
    wait_cnt_nxt   = wait_cnt;
    addr_c         = '0;
    wdata_c        = '0;

    if (reset) begin
      if (cpu_elig && (wait_cnt == WAIT_MAX)) begin
        cpu_gnt_c = 1'b1;
      end else if (bus.dsp_req && bus.dsp_urgent) begin
        dsp_gnt_c = 1'b1;
      end else if (cpu_elig && bus.dsp_req) begin
        if (last_owner == OWN_DSP) cpu_gnt_c = 1'b1;
        else                       dsp_gnt_c = 1'b1;
      end else if (cpu_elig) begin
        cpu_gnt_c = 1'b1;
      end else if (bus.dsp_req) begin
        dsp_gnt_c = 1'b1;
      end
    end

    if (cpu_gnt_c) begin
      last_owner_nxt = OWN_CPU;
      addr_c         = bus.cpu_addr;
      wdata_c        = bus.cpu_wdata;
    end else if (dsp_gnt_c) begin
      last_owner_nxt = OWN_DSP;
      addr_c         = bus.dsp_addr;
    end

    if (cpu_gnt_c || !cpu_elig) wait_cnt_nxt = '0;
    else if (wait_cnt != WAIT_MAX) wait_cnt_nxt = wait_cnt + WAIT_W'(1);
  end

  assign bus.cpu_gnt    = cpu_gnt_c;
  assign bus.dsp_gnt    = dsp_gnt_c;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt_c;
  assign bus.mem_en     = cpu_gnt_c | dsp_gnt_c;
  assign bus.mem_we     = cpu_gnt_c & bus.cpu_we;
  assign bus.mem_addr   = addr_c;
  assign bus.mem_wdata  = wdata_c;
  assign bus.cpu_rvalid = rv_cpu;
  assign bus.dsp_rvalid = rv_dsp;
  assign bus.cpu_rdata  = rv_cpu ? bus.mem_rdata : '0;
  assign bus.dsp_rdata  = rv_dsp ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_pixmem_arbiter.sv
// Bench for pixmem_arbiter: per-scenario tasks plus a read-return scoreboard.
module tb_pixmem_arbiter;

  localparam int unsigned AW = 17;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 8;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  pixmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  pixmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 1-cycle read latency, junk on the data bus when not reading
  logic [DW-1:0] mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hC0DE0000 ^ {15'd0, a};
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr] = bus.mem_wdata;
      bus.mem_rdata <= 32'hBAD0BAD0;
    end else if (bus.mem_en) begin
      bus.mem_rdata <= model_read(bus.mem_addr);
    end else begin
      bus.mem_rdata <= 32'hBAD0BAD0;
    end
  end

  // Scoreboard: expected read returns pushed at grant, popped on rvalid
  typedef struct {
    logic          to_dsp;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (bus.cpu_rvalid || bus.dsp_rvalid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: cpu_rvalid=%0b dsp_rvalid=%0b with nothing outstanding", bus.cpu_rvalid, bus.dsp_rvalid);
      end else begin
        e = sb.pop_front();
        if (bus.cpu_rvalid !== !e.to_dsp || bus.dsp_rvalid !== e.to_dsp) begin
          bad++;
          $display("FAIL sb_owner: cpu_rvalid=%0b dsp_rvalid=%0b expected to_dsp=%0b", bus.cpu_rvalid, bus.dsp_rvalid, e.to_dsp);
        end else if ((e.to_dsp ? bus.dsp_rdata : bus.cpu_rdata) !== e.data) begin
          bad++;
          $display("FAIL sb_data: got %h expected %h", e.to_dsp ? bus.dsp_rdata : bus.cpu_rdata, e.data);
        end
      end
    end else if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_missing: no rvalid one cycle after read grant (%0d outstanding)", sb.size());
      sb.delete();
    end
    if (!bus.cpu_rvalid) begin
      total++;
      if (bus.cpu_rdata !== '0) begin
        bad++;
        $display("FAIL cpu_rdata_idle: got %h expected 0", bus.cpu_rdata);
      end
    end
    if (!bus.dsp_rvalid) begin
      total++;
      if (bus.dsp_rdata !== '0) begin
        bad++;
        $display("FAIL dsp_rdata_idle: got %h expected 0", bus.dsp_rdata);
      end
    end
    if (bus.mem_en && !bus.mem_we) sb.push_back('{bus.dsp_gnt, model_read(bus.mem_addr)});
  end

  task automatic idle_inputs();
    bus.halt       = 1'b0;
    bus.cpu_req    = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    bus.dsp_req    = 1'b0;
    bus.dsp_urgent = 1'b0;
    bus.dsp_addr   = '0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    bus.cpu_req    = 1'b1;
    bus.dsp_req    = 1'b1;
    bus.dsp_urgent = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      total++;
      if (bus.cpu_gnt !== 1'b0 || bus.dsp_gnt !== 1'b0 || bus.mem_en !== 1'b0 ||
          bus.cpu_rvalid !== 1'b0 || bus.dsp_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold: gnt=%b%b mem_en=%b rvalid=%b%b expected all 0",
                 bus.cpu_gnt, bus.dsp_gnt, bus.mem_en, bus.cpu_rvalid, bus.dsp_rvalid);
      end
    end
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      total++;
      if (bus.cpu_gnt !== 1'b0 || bus.dsp_gnt !== 1'b0 || bus.mem_en !== 1'b0 ||
          bus.cpu_stall !== 1'b0 || bus.cpu_rvalid !== 1'b0 || bus.dsp_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle: gnt=%b%b mem_en=%b stall=%b rvalid=%b%b expected all 0",
                 bus.cpu_gnt, bus.dsp_gnt, bus.mem_en, bus.cpu_stall, bus.cpu_rvalid, bus.dsp_rvalid);
      end
    end
  endtask

  task automatic test_round_robin();
    logic exp_cpu;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = AW'(32'h40 + i);
      bus.dsp_req  = 1'b1;
      bus.dsp_addr = AW'(32'h100 + i);
      #1;
      exp_cpu = (i % 2 == 0);
      total++;
      if (bus.cpu_gnt !== exp_cpu || bus.dsp_gnt !== !exp_cpu || bus.cpu_stall !== !exp_cpu) begin
        bad++;
        $display("FAIL rr_cycle%0d: cpu_gnt=%b dsp_gnt=%b stall=%b expected %b %b %b",
                 i, bus.cpu_gnt, bus.dsp_gnt, bus.cpu_stall, exp_cpu, !exp_cpu, !exp_cpu);
      end
      total++;
      if (bus.mem_addr !== (exp_cpu ? bus.cpu_addr : bus.dsp_addr) || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0) begin
        bad++;
        $display("FAIL rr_port%0d: mem_addr=%h en=%b we=%b", i, bus.mem_addr, bus.mem_en, bus.mem_we);
      end
    end
    idle_cycle();
  endtask

  task automatic test_read_path();
    mem[AW'(32'h10)] = 32'hDEADBEEF;
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = AW'(32'h10);
    #1;
    total++;
    if (bus.cpu_gnt !== 1'b1 || bus.mem_addr !== AW'(32'h10) || bus.mem_we !== 1'b0) begin
      bad++;
      $display("FAIL rd_grant: gnt=%b addr=%h we=%b expected 1 00010 0", bus.cpu_gnt, bus.mem_addr, bus.mem_we);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    total++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF || bus.dsp_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL rd_return: cpu_rvalid=%b cpu_rdata=%h dsp_rvalid=%b expected 1 deadbeef 0",
               bus.cpu_rvalid, bus.cpu_rdata, bus.dsp_rvalid);
    end
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = AW'(32'h20);
    bus.cpu_wdata = 32'h12345678;
    #1;
    total++;
    if (bus.cpu_rvalid !== 1'b0 || bus.cpu_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h12345678) begin
      bad++;
      $display("FAIL wr_issue: rvalid=%b gnt=%b we=%b wdata=%h expected 0 1 1 12345678",
               bus.cpu_rvalid, bus.cpu_gnt, bus.mem_we, bus.mem_wdata);
    end
    @(negedge clk);
    bus.cpu_we   = 1'b0;
    #1;
    total++;
    if (bus.cpu_rvalid !== 1'b0 || bus.dsp_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL wr_no_rvalid: cpu_rvalid=%b dsp_rvalid=%b expected 0 0", bus.cpu_rvalid, bus.dsp_rvalid);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    total++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'h12345678) begin
      bad++;
      $display("FAIL wr_readback: rvalid=%b rdata=%h expected 1 12345678", bus.cpu_rvalid, bus.cpu_rdata);
    end
    idle_cycle();
  endtask

  task automatic test_starvation();
    logic exp_cpu;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.cpu_req    = 1'b1;
      bus.cpu_we     = 1'b0;
      bus.cpu_addr   = AW'(32'h200);
      bus.dsp_req    = 1'b1;
      bus.dsp_urgent = 1'b1;
      bus.dsp_addr   = AW'(32'h300 + i);
      #1;
      exp_cpu = (i == int'(MW));
      total++;
      if (bus.cpu_gnt !== exp_cpu || bus.dsp_gnt !== !exp_cpu) begin
        bad++;
        $display("FAIL starve_cycle%0d: cpu_gnt=%b dsp_gnt=%b expected %b %b",
                 i, bus.cpu_gnt, bus.dsp_gnt, exp_cpu, !exp_cpu);
      end
    end
    idle_cycle();
  endtask

  task automatic test_halt();
    logic dreq;
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = AW'(32'h30);
    #1;
    total++;
    if (bus.cpu_gnt !== 1'b1) begin
      bad++;
      $display("FAIL halt_pre_grant: cpu_gnt=%b expected 1", bus.cpu_gnt);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dreq         = (i % 2 == 0);
      bus.halt     = 1'b1;
      bus.cpu_req  = 1'b1;
      bus.dsp_req  = dreq;
      bus.dsp_addr = AW'(32'h400 + i);
      #1;
      if (i == 0) begin
        total++;
        if (bus.cpu_rvalid !== 1'b1) begin
          bad++;
          $display("FAIL halt_rvalid_fires: cpu_rvalid=%b expected 1", bus.cpu_rvalid);
        end
      end
      total++;
      if (bus.cpu_gnt !== 1'b0 || bus.cpu_stall !== 1'b1 || dut.wait_cnt !== '0 || bus.dsp_gnt !== dreq) begin
        bad++;
        $display("FAIL halt_cycle%0d: cpu_gnt=%b stall=%b wait_cnt=%0d dsp_gnt=%b expected 0 1 0 %b",
                 i, bus.cpu_gnt, bus.cpu_stall, dut.wait_cnt, bus.dsp_gnt, dreq);
      end
    end
    @(negedge clk);
    bus.halt    = 1'b0;
    bus.dsp_req = 1'b0;
    #1;
    total++;
    if (bus.cpu_gnt !== 1'b1 || bus.cpu_stall !== 1'b0) begin
      bad++;
      $display("FAIL halt_release: cpu_gnt=%b stall=%b expected 1 0", bus.cpu_gnt, bus.cpu_stall);
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    #1;
    total++;
    if (dut.last_owner !== 1'b0) begin
      bad++;
      $display("FAIL mid_pre_owner: last_owner=%b expected 0", dut.last_owner);
    end
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = AW'(32'h10);
    #1;
    total++;
    if (bus.cpu_gnt !== 1'b1) begin
      bad++;
      $display("FAIL mid_grant: cpu_gnt=%b expected 1", bus.cpu_gnt);
    end
    #2;
    reset = 1'b0;
    sb.delete();
    #1;
    total++;
    if (bus.cpu_gnt !== 1'b0 || bus.mem_en !== 1'b0) begin
      bad++;
      $display("FAIL mid_gnt_forced: cpu_gnt=%b mem_en=%b expected 0 0", bus.cpu_gnt, bus.mem_en);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      total++;
      if (bus.cpu_rvalid !== 1'b0 || dut.last_owner !== 1'b1) begin
        bad++;
        $display("FAIL mid_drop%0d: cpu_rvalid=%b last_owner=%b expected 0 1", i, bus.cpu_rvalid, dut.last_owner);
      end
    end
    @(negedge clk);
    reset       = 1'b1;
    bus.dsp_req = 1'b1;
    bus.dsp_addr = AW'(32'h500);
    #1;
    total++;
    if (bus.cpu_rvalid !== 1'b0 || bus.cpu_gnt !== 1'b1 || bus.dsp_gnt !== 1'b0) begin
      bad++;
      $display("FAIL mid_first_tie: rvalid=%b cpu_gnt=%b dsp_gnt=%b expected 0 1 0",
               bus.cpu_rvalid, bus.cpu_gnt, bus.dsp_gnt);
    end
    idle_cycle();
    idle_cycle();
  endtask

  initial begin
    bus.mem_rdata = '0;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_read_path();
    test_starvation();
    test_halt();
    test_reset_mid_read();
    @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
